// File: rtl/alu181_pkg.sv
// Shared definitions for the pipelined 74181-style ALU: S-codes, op control struct, width helper.
// ALU181_ACC_EN adds the acc_sel bit to the op control struct.
package alu181_pkg;

  localparam logic [3:0] S_SUB = 4'b0110;
  localparam logic [3:0] S_ADD = 4'b1001;
  localparam logic [3:0] S_DBL = 4'b1100;
  localparam logic [3:0] S_DEC = 4'b1111;

  typedef struct packed {
    logic [3:0] s;
    logic       m;
    logic       cn_n;
`ifdef ALU181_ACC_EN
    logic       acc_sel;
`endif
  } op_ctl_t;

  function automatic int unsigned alu_width(input int unsigned slices);
    return 4 * slices;
  endfunction

endpackage

// File: rtl/alu181_pipe_if.sv
// Operand/result handshake bundle for alu181_pipe.
// ALU181_ACC_EN adds the acc_sel op field.
interface alu181_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       s;
  logic             m;
  logic             cn_n;
`ifdef ALU181_ACC_EN
  logic             acc_sel;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             co_n;
  logic             p_n;
  logic             g_n;
  logic             aeqb;
  logic             zero;

  modport master (
`ifdef ALU181_ACC_EN
    output acc_sel,
`endif
    output in_valid, a, b, s, m, cn_n, out_ready,
    input  in_ready, out_valid, f, co_n, p_n, g_n, aeqb, zero
  );

  modport slave (
`ifdef ALU181_ACC_EN
    input  acc_sel,
`endif
    input  in_valid, a, b, s, m, cn_n, out_ready,
    output in_ready, out_valid, f, co_n, p_n, g_n, aeqb, zero
  );
endinterface

// File: rtl/alu181_slice.sv
// Combinational 4-bit 74181 slice: X/Y operand select, logic table, sum and slice P/G.
module alu181_slice
  import alu181_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic [3:0] i_s,
  input  logic       i_m,
  input  logic       i_cin,
  input  logic       i_cin0,
  output logic [3:0] o_f,
  output logic       o_cout,
  output logic       o_cout0,
  output logic       o_p
);
  logic [3:0] w_x, w_y, w_nb, w_log;
  logic [4:0] w_xy, w_sum;

  assign w_nb = ~i_b;

  always_comb begin
    w_x = i_a;
    w_y = '0;
    case (i_s)
      4'h0:  ;
      4'h1:  w_x = i_a | i_b;
      4'h2:  w_x = i_a | w_nb;
      4'h3:  begin w_x = '0; w_y = '1; end
      4'h4:  w_y = i_a & w_nb;
      4'h5:  begin w_x = i_a | i_b; w_y = i_a & w_nb; end
      S_SUB: w_y = w_nb;
      4'h7:  begin w_x = i_a & w_nb; w_y = '1; end
      4'h8:  w_y = i_a & i_b;
      S_ADD: w_y = i_b;
      4'hA:  begin w_x = i_a | w_nb; w_y = i_a & i_b; end
      4'hB:  begin w_x = i_a & i_b; w_y = '1; end
      S_DBL: w_y = i_a;
      4'hD:  begin w_x = i_a | i_b; w_y = i_a; end
      4'hE:  begin w_x = i_a | w_nb; w_y = i_a; end
      S_DEC: w_y = '1;
    endcase
  end

  always_comb begin
    w_log = '0;
    case (i_s)
      4'h0: w_log = ~i_a;
      4'h1: w_log = ~(i_a | i_b);
      4'h2: w_log = ~i_a & i_b;
      4'h3: w_log = '0;
      4'h4: w_log = ~(i_a & i_b);
      4'h5: w_log = w_nb;
      4'h6: w_log = i_a ^ i_b;
      4'h7: w_log = i_a & w_nb;
      4'h8: w_log = ~i_a | i_b;
      4'h9: w_log = ~(i_a ^ i_b);
      4'hA: w_log = i_b;
      4'hB: w_log = i_a & i_b;
      4'hC: w_log = '1;
      4'hD: w_log = i_a | w_nb;
      4'hE: w_log = i_a | i_b;
      4'hF: w_log = i_a;
    endcase
  end

  // Carry-in-free partial sum feeds both the real ripple and the cin=0 generate chain
  assign w_xy    = {1'b0, w_x} + {1'b0, w_y};
  assign w_sum   = w_xy + {4'b0, i_cin};
  assign o_cout  = w_sum[4];
  assign o_cout0 = w_xy[4] | (&w_xy[3:0] & i_cin0);
  assign o_p     = &(w_x | w_y);
  assign o_f     = i_m ? w_log : w_sum[3:0];
endmodule

// File: rtl/alu181_pipe.sv
// Pipelined WIDTH=4*SLICES 74181-style ALU with valid/ready handshake, latency PIPE (1 or 2).
// ALU181_ACC_EN adds an accumulator selectable as operand A via acc_sel.
module alu181_pipe
  import alu181_pkg::*;
#(
  parameter int unsigned SLICES = 2,
  parameter int unsigned PIPE   = 2
)(
  input  logic         clk,
  input  logic         rst_n,
  alu181_pipe_if.slave bus
);
  localparam int unsigned WIDTH = alu_width(SLICES);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    op_ctl_t          ctl;
  } op_t;

  op_t              w_in_op, w_c_op;
  logic             w_c_v, w_out_adv, w_load;
  logic [WIDTH-1:0] w_a, w_f;
  logic [SLICES:0]  w_c, w_c0;
  logic [SLICES-1:0] w_pg;
  logic             r_out_v, r_co_n, r_p_n, r_g_n, r_aeqb, r_zero;
  logic [WIDTH-1:0] r_f;

  always_comb begin
    w_in_op          = '0;
    w_in_op.a        = bus.a;
    w_in_op.b        = bus.b;
    w_in_op.ctl.s    = bus.s;
    w_in_op.ctl.m    = bus.m;
    w_in_op.ctl.cn_n = bus.cn_n;
`ifdef ALU181_ACC_EN
    w_in_op.ctl.acc_sel = bus.acc_sel;
`endif
  end

  assign w_out_adv = !r_out_v || bus.out_ready;
  assign w_load    = w_c_v && w_out_adv;

  generate
    if (PIPE == 2) begin : g_pipe2
      op_t  r_op;
      logic r_op_v;
      logic w_in_xfer;

      assign w_in_xfer    = bus.in_valid && bus.in_ready;
      assign bus.in_ready = rst_n && (!r_op_v || w_out_adv);

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_op_v <= 1'b0;
          r_op   <= '0;
        end else if (w_in_xfer) begin
          r_op_v <= 1'b1;
          r_op   <= w_in_op;
        end else if (w_out_adv) begin
          r_op_v <= 1'b0;
        end
      end

      assign w_c_op = r_op;
      assign w_c_v  = r_op_v;
    end else begin : g_pipe1
      assign bus.in_ready = rst_n && w_out_adv;
      assign w_c_op       = w_in_op;
      assign w_c_v        = bus.in_valid;
    end
  endgenerate

`ifdef ALU181_ACC_EN
  logic [WIDTH-1:0] r_acc;

  // acc updates as each op enters the output register, so the next op to compute already sees it
  always_ff @(posedge clk) begin
    if (!rst_n)      r_acc <= '0;
    else if (w_load) r_acc <= w_f;
  end

  assign w_a = w_c_op.ctl.acc_sel ? r_acc : w_c_op.a;
`else
  assign w_a = w_c_op.a;
`endif

  assign w_c[0]  = !w_c_op.ctl.cn_n;
  assign w_c0[0] = 1'b0;

  for (genvar i = 0; i < SLICES; i++) begin : g_slice
    alu181_slice u_slice (
      .i_a     (w_a[4*i +: 4]),
      .i_b     (w_c_op.b[4*i +: 4]),
      .i_s     (w_c_op.ctl.s),
      .i_m     (w_c_op.ctl.m),
      .i_cin   (w_c[i]),
      .i_cin0  (w_c0[i]),
      .o_f     (w_f[4*i +: 4]),
      .o_cout  (w_c[i+1]),
      .o_cout0 (w_c0[i+1]),
      .o_p     (w_pg[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_v <= 1'b0;
      r_f     <= '0;
      r_co_n  <= 1'b1;
      r_p_n   <= 1'b1;
      r_g_n   <= 1'b1;
      r_aeqb  <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_load) begin
      r_out_v <= 1'b1;
      r_f     <= w_f;
      r_co_n  <= w_c_op.ctl.m | ~w_c[SLICES];
      r_p_n   <= w_c_op.ctl.m | ~&w_pg;
      r_g_n   <= w_c_op.ctl.m | ~w_c0[SLICES];
      r_aeqb  <= &w_f;
      r_zero  <= ~|w_f;
    end else if (bus.out_ready) begin
      r_out_v <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_v;
  assign bus.f         = r_f;
  assign bus.co_n      = r_co_n;
  assign bus.p_n       = r_p_n;
  assign bus.g_n       = r_g_n;
  assign bus.aeqb      = r_aeqb;
  assign bus.zero      = r_zero;
endmodule

// File: tb/tb_alu181_pipe.sv
// Self-checking bench for alu181_pipe (SLICES=2, PIPE=2): directed cases plus random ops vs a reference model.
// The accumulator case runs only when ALU181_ACC_EN is defined.
`timescale 1ns/1ps
module tb_alu181_pipe;
  import alu181_pkg::*;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] f;
    logic         co_n;
    logic         p_n;
    logic         g_n;
    logic         aeqb;
    logic         zero;
  } res_t;

  localparam res_t RST = res_t'{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu181_pipe_if #(.WIDTH(W)) bus ();

  alu181_pipe #(.SLICES(2), .PIPE(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned n_out = 0;
  res_t        q[$];
  res_t        lit;
  res_t        held;
  logic        use_lit = 1'b0;
  logic        hold_v = 1'b0;
  logic        last_in_x = 1'b0;
  logic        rnd_ready = 1'b0;
  logic        tb_acc_sel = 1'b0;
  logic [W-1:0] m_acc = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: 74181 function table applied to whole words with integer arithmetic
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] s, input logic m, input logic cn_n);
    res_t r;
    logic [W-1:0] nb;
    int unsigned x, y, sum, all1;
    nb = ~b;
    all1 = (1 << W) - 1;
    r = RST;
    if (m) begin
      case (s)
        4'h0: r.f = ~a;
        4'h1: r.f = ~(a | b);
        4'h2: r.f = ~a & b;
        4'h3: r.f = '0;
        4'h4: r.f = ~(a & b);
        4'h5: r.f = nb;
        4'h6: r.f = a ^ b;
        4'h7: r.f = a & nb;
        4'h8: r.f = ~a | b;
        4'h9: r.f = ~(a ^ b);
        4'hA: r.f = b;
        4'hB: r.f = a & b;
        4'hC: r.f = '1;
        4'hD: r.f = a | nb;
        4'hE: r.f = a | b;
        default: r.f = a;
      endcase
    end else begin
      x = a;
      y = 0;
      case (s)
        4'h0: ;
        4'h1: x = a | b;
        4'h2: x = a | nb;
        4'h3: begin x = 0; y = all1; end
        4'h4: y = a & nb;
        4'h5: begin x = a | b; y = a & nb; end
        4'h6: y = nb;
        4'h7: begin x = a & nb; y = all1; end
        4'h8: y = a & b;
        4'h9: y = b;
        4'hA: begin x = a | nb; y = a & b; end
        4'hB: begin x = a & b; y = all1; end
        4'hC: y = a;
        4'hD: begin x = a | b; y = a; end
        4'hE: begin x = a | nb; y = a; end
        default: y = all1;
      endcase
      sum    = x + y + (cn_n ? 0 : 1);
      r.f    = W'(sum);
      r.co_n = (sum <= all1);
      r.g_n  = ((x + y) <= all1);
      r.p_n  = ((x | y) != all1);
    end
    r.aeqb = (r.f == '1);
    r.zero = (r.f == '0);
    return r;
  endfunction

  function automatic res_t cur_res();
    return res_t'{bus.f, bus.co_n, bus.p_n, bus.g_n, bus.aeqb, bus.zero};
  endfunction

  task automatic step();
    res_t e, o;
    logic [W-1:0] ae;
    if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    @(negedge clk);
    o = cur_res();
    last_in_x = bus.in_valid && bus.in_ready;
    if (last_in_x) begin
      ae = tb_acc_sel ? m_acc : bus.a;
      e = use_lit ? lit : model(ae, bus.b, bus.s, bus.m, bus.cn_n);
      m_acc = e.f;
      q.push_back(e);
    end
    if (hold_v) chk("hold_stable", 32'({bus.out_valid, o}), 32'({1'b1, held}));
    hold_v = bus.out_valid && !bus.out_ready;
    held = o;
    if (bus.out_valid && bus.out_ready) begin
      n_out++;
      chk("out_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("result", 32'(o), 32'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                        input logic m, input logic cn_n, input logic sel);
    bus.a = a;
    bus.b = b;
    bus.s = s;
    bus.m = m;
    bus.cn_n = cn_n;
    tb_acc_sel = sel;
`ifdef ALU181_ACC_EN
    bus.acc_sel = sel;
`endif
    bus.in_valid = 1'b1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                      input logic m, input logic cn_n, input logic sel);
    set_op(a, b, s, m, cn_n, sel);
    for (int k = 0; k < 64; k++) begin
      step();
      if (last_in_x) break;
    end
    chk("send_accept", 32'(last_in_x), 32'd1);
  endtask

  task automatic send_lit(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                          input logic m, input logic cn_n, input logic sel, input res_t exp);
    lit = exp;
    use_lit = 1'b1;
    send(a, b, s, m, cn_n, sel);
    use_lit = 1'b0;
  endtask

  task automatic send_rand(input logic allow_acc);
    logic sel;
    sel = 1'b0;
`ifdef ALU181_ACC_EN
    sel = allow_acc && ($urandom_range(0, 3) == 0);
`endif
    if (!allow_acc) sel = 1'b0;
    send(W'($urandom), W'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), sel);
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    rnd_ready = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 100 && (q.size() != 0 || bus.out_valid); k++) step();
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int unsigned cnt, n0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    set_op('0, '0, 4'h0, 1'b0, 1'b1, 1'b0);
    bus.in_valid = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_outputs", 32'(cur_res()), 32'(RST));
    rst_n = 1'b1;

    // Add with two-cycle latency
    bus.out_ready = 1'b0;
    send_lit(8'h7F, 8'h01, S_ADD, 1'b0, 1'b1, 1'b0, res_t'{8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    chk("lat_1clk", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b0;
    step();
    chk("lat_2clk", 32'(bus.out_valid), 32'd1);
    drain();

    // Carry, subtract/compare, logic-mode directed values
    send_lit(8'hFF, 8'h00, S_ADD, 1'b0, 1'b0, 1'b0, res_t'{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
    send_lit(8'h05, 8'h05, S_SUB, 1'b0, 1'b0, 1'b0, res_t'{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
    send_lit(8'h05, 8'h05, S_SUB, 1'b0, 1'b1, 1'b0, res_t'{8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
    send_lit(8'hF0, 8'h3C, 4'h6, 1'b1, 1'b0, 1'b0, res_t'{8'hCC, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    send_lit(8'hF0, 8'h3C, 4'h3, 1'b1, 1'b0, 1'b0, res_t'{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
    send_lit(8'h80, 8'h80, S_ADD, 1'b0, 1'b1, 1'b0, res_t'{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    drain();

    // Back-pressure: four ops against a stalled consumer
    n0 = n_out;
    cnt = 0;
    bus.out_ready = 1'b0;
    set_op(W'($urandom), W'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      if (last_in_x) begin
        cnt++;
        set_op(W'($urandom), W'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      end
    end
    chk("stall_accepts", 32'(cnt), 32'd2);
    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20 && cnt < 4; k++) begin
      step();
      if (last_in_x) begin
        cnt++;
        set_op(W'($urandom), W'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      end
    end
    drain();
    chk("stall_outputs", 32'(n_out - n0), 32'd4);

    // Reset with two ops in flight
    bus.out_ready = 1'b0;
    send_rand(1'b0);
    send_rand(1'b0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready_mid", 32'(bus.in_ready), 32'd0);
    step();
    q.delete();
    hold_v = 1'b0;
    m_acc = '0;
    rst_n = 1'b1;
    chk("rst_flush_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_flush_outputs", 32'(cur_res()), 32'(RST));
    n0 = n_out;
    bus.out_ready = 1'b1;
    repeat (4) step();
    chk("no_stale", 32'(n_out - n0), 32'd0);

`ifdef ALU181_ACC_EN
    // Dependent op back-to-back through the accumulator
    send_lit(8'h01, 8'h01, S_ADD, 1'b0, 1'b1, 1'b0, res_t'{8'h02, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    send_lit(8'hAA, 8'h01, S_ADD, 1'b0, 1'b1, 1'b1, res_t'{8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    drain();
`endif

    // Random traffic with random gaps and consumer stalls
    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        bus.in_valid = 1'b0;
        step();
      end
      send_rand(1'b1);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
